// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// Optional overflow flag present when SERIAL_ADD_SUB_OVF_EN is defined.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 4
);
  logic             SerAddSub_i_Start;
  logic [WIDTH-1:0] SerAddSub_i_A;
  logic [WIDTH-1:0] SerAddSub_i_B;
  logic             SerAddSub_i_fSub;
  logic [WIDTH-1:0] SerAddSub_o_S;
  logic             SerAddSub_o_C;
  logic             SerAddSub_o_Busy;
  logic             SerAddSub_o_Done;
`ifdef SERIAL_ADD_SUB_OVF_EN
  logic             SerAddSub_o_V;
`endif

  modport master (
`ifdef SERIAL_ADD_SUB_OVF_EN
    input  SerAddSub_o_V,
`endif
    output SerAddSub_i_Start,
    output SerAddSub_i_A,
    output SerAddSub_i_B,
    output SerAddSub_i_fSub,
    input  SerAddSub_o_S,
    input  SerAddSub_o_C,
    input  SerAddSub_o_Busy,
    input  SerAddSub_o_Done
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_OVF_EN
    output SerAddSub_o_V,
`endif
    input  SerAddSub_i_Start,
    input  SerAddSub_i_A,
    input  SerAddSub_i_B,
    input  SerAddSub_i_fSub,
    output SerAddSub_o_S,
    output SerAddSub_o_C,
    output SerAddSub_o_Busy,
    output SerAddSub_o_Done
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement add/sub: one bit per clock, LSB first, WIDTH-cycle RUN.
// Define SERIAL_ADD_SUB_OVF_EN to add the signed-overflow output SerAddSub_o_V.
module serial_add_sub #(
  parameter int unsigned WIDTH = 4
) (
  input logic            SerAddSub_i_Clk,
  input logic            SerAddSub_i_Rst,
  serial_add_sub_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_q;
  logic             cy_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;

  logic             sum_bit, cy_next, accept;
  logic [WIDTH-1:0] res_full;

  always_comb begin
    sum_bit  = a_q[0] ^ b_q[0] ^ cy_q;
    cy_next  = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);
    res_full = {sum_bit, res_q};
    accept   = bus.SerAddSub_i_Start && ((state_q == IDLE) || (state_q == DONE));
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic v_q;
`endif

  always_ff @(posedge SerAddSub_i_Clk) begin
    if (SerAddSub_i_Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
      v_q     <= 1'b0;
`endif
    end else if (accept) begin
      // Subtract = A + ~B + 1: invert B now, seed the carry with the +1.
      a_q     <= bus.SerAddSub_i_A;
      b_q     <= bus.SerAddSub_i_B ^ {WIDTH{bus.SerAddSub_i_fSub}};
      cy_q    <= bus.SerAddSub_i_fSub;
      cnt_q   <= '0;
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_full[WIDTH-1:1];
          cy_q  <= cy_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_q <= DONE;
            s_q     <= res_full;
            c_q     <= cy_next;
`ifdef SERIAL_ADD_SUB_OVF_EN
            // cy_q here is the carry into the MSB.
            v_q     <= cy_q ^ cy_next;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.SerAddSub_o_S    = s_q;
  assign bus.SerAddSub_o_C    = c_q;
  assign bus.SerAddSub_o_Busy = (state_q == RUN);
  assign bus.SerAddSub_o_Done = (state_q == DONE);
`ifdef SERIAL_ADD_SUB_OVF_EN
  assign bus.SerAddSub_o_V    = v_q;
`endif
endmodule
